// File: rtl/covariance_predict.sv
// EKF prediction-covariance stage: P_pred = F*P*F^T + diag(Qd), 4x4 signed fixed point.
// A single shared multiply-accumulate is stepped through both matrix products by an FSM.
module covariance_predict #(
    parameter int unsigned N = 32,
    parameter int unsigned Q = 18
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [16*N-1:0]   F,
    input  logic [16*N-1:0]   F_transpose,
    input  logic [16*N-1:0]   P,
    input  logic [4*N-1:0]    Qd,
    output logic              busy,
    output logic              done,
    output logic [16*N-1:0]   P_pred,
    output logic              ovf
);

    localparam int unsigned W2 = 2 * N;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL1 = 2'd1,
        MUL2 = 2'd2,
        FIN  = 2'd3
    } state_e;

    state_e                state_q, state_d;
    logic [5:0]            cnt_q, cnt_d;
    logic signed [N-1:0]   acc_q, acc_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  ovf_q, ovf_d;
    logic signed [N-1:0]   f_q [16],  f_d [16];
    logic signed [N-1:0]   ft_q [16], ft_d [16];
    logic signed [N-1:0]   p_q [16],  p_d [16];
    logic signed [N-1:0]   qd_q [4],  qd_d [4];
    logic signed [N-1:0]   t_q [16],  t_d [16];
    logic signed [N-1:0]   s_q [16],  s_d [16];
    logic signed [N-1:0]   pp_q [16], pp_d [16];

    logic [1:0]            r_c, c_c, k_c;
    logic signed [N-1:0]   mac_a_c, mac_b_c, prod_c, acc_in_c, sum_c, qsum_c;
    logic signed [W2-1:0]  full_c, shifted_c;
    logic                  prod_ovf_c, add_ovf_c, q_ovf_c;

    assign r_c = cnt_q[5:4];
    assign c_c = cnt_q[3:2];
    assign k_c = cnt_q[1:0];

    // Shared MAC: operand select, floor-shifted product, wrapping accumulate and Qd add.
    always_comb begin
        mac_a_c = '0;
        mac_b_c = '0;
        if (state_q == MUL1) begin
            mac_a_c = f_q[{r_c, k_c}];
            mac_b_c = p_q[{k_c, c_c}];
        end else if (state_q == MUL2) begin
            mac_a_c = t_q[{r_c, k_c}];
            mac_b_c = ft_q[{k_c, c_c}];
        end
        full_c     = W2'(mac_a_c) * W2'(mac_b_c);
        shifted_c  = full_c >>> Q;
        prod_c     = shifted_c[N-1:0];
        prod_ovf_c = (shifted_c[W2-1:N-1] != '0) && (shifted_c[W2-1:N-1] != '1);
        acc_in_c   = (k_c == 2'd0) ? '0 : acc_q;
        sum_c      = acc_in_c + prod_c;
        add_ovf_c  = (acc_in_c[N-1] == prod_c[N-1]) && (sum_c[N-1] != acc_in_c[N-1]);
        qsum_c     = sum_c + qd_q[r_c];
        q_ovf_c    = (sum_c[N-1] == qd_q[r_c][N-1]) && (qsum_c[N-1] != sum_c[N-1]);
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        ovf_d   = ovf_q;
        f_d     = f_q;
        ft_d    = ft_q;
        p_d     = p_q;
        qd_d    = qd_q;
        t_d     = t_q;
        s_d     = s_q;
        pp_d    = pp_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    for (int i = 0; i < 16; i++) begin
                        f_d[i]  = F[i*N +: N];
                        ft_d[i] = F_transpose[i*N +: N];
                        p_d[i]  = P[i*N +: N];
                    end
                    for (int i = 0; i < 4; i++) begin
                        qd_d[i] = Qd[i*N +: N];
                    end
                    busy_d  = 1'b1;
                    ovf_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = MUL1;
                end
            end
            MUL1: begin
                acc_d = sum_c;
                ovf_d = ovf_q | prod_ovf_c | add_ovf_c;
                if (k_c == 2'd3) begin
                    t_d[{r_c, c_c}] = sum_c;
                end
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'd63) begin
                    state_d = MUL2;
                end
            end
            MUL2: begin
                acc_d = sum_c;
                ovf_d = ovf_q | prod_ovf_c | add_ovf_c;
                if (k_c == 2'd3) begin
                    if (r_c == c_c) begin
                        s_d[{r_c, c_c}] = qsum_c;
                        ovf_d           = ovf_q | prod_ovf_c | add_ovf_c | q_ovf_c;
                    end else begin
                        s_d[{r_c, c_c}] = sum_c;
                    end
                end
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'd63) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                pp_d    = s_q;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            f_q     <= '{default: '0};
            ft_q    <= '{default: '0};
            p_q     <= '{default: '0};
            qd_q    <= '{default: '0};
            t_q     <= '{default: '0};
            s_q     <= '{default: '0};
            pp_q    <= '{default: '0};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
            f_q     <= f_d;
            ft_q    <= ft_d;
            p_q     <= p_d;
            qd_q    <= qd_d;
            t_q     <= t_d;
            s_q     <= s_d;
            pp_q    <= pp_d;
        end
    end

    always_comb begin
        for (int i = 0; i < 16; i++) begin
            P_pred[i*N +: N] = pp_q[i];
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign ovf  = ovf_q;

endmodule
